lsu_mem_stage: RTL
==================

# lsu_mem_stage

Load/store unit for the memory stage of the RV32I core, directly downstream of the execute-stage ALU. It takes the ALU's computed effective address (`out_alu`) plus store data and `funct3`, and runs one memory transaction at a time over a req/gnt/rvalid data-memory port. It returns sign- or zero-extended load data to writeback and holds the pipeline stalled while a transaction is in flight.

## Interface
- `W`, 32, data/address width (only 32 supported)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  memory op presented by EX this cycle
- `in_ready`  out  1  stage can accept an op (high only in IDLE)
- `in_addr`  in  32  effective address (ALU result)
- `in_wdata`  in  32  store data (rs2)
- `in_we`  in  1  1 = store, 0 = load
- `in_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- `stall`  out  1  pipeline hold; high whenever state != IDLE
- `mem_req`  out  1  request to data memory
- `mem_gnt`  in  1  request accepted this cycle
- `mem_addr`  out  32  word-aligned address, `{in_addr[31:2],2'b00}`
- `mem_we`  out  1  write enable
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-replicated store data
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read word
- `out_valid`  out  1  one-cycle completion pulse to writeback
- `out_rdata`  out  32  extended load data (0 for stores and faults)
- `out_fault`  out  1  misaligned address or unsupported funct3; valid with `out_valid`

## Operation
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE: `in_ready`=1. On `in_valid`, register addr, wdata, we, funct3.
  - If fault (H/HU with `addr[0]`=1, W with `addr[1:0]`!=0, funct3 011/110/111, or store with funct3 100/101): go to RESP with fault set. No memory access occurs.
  - Otherwise go to REQ.
- REQ: `mem_req`=1. `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are held stable until `mem_gnt`. On grant, a store goes to RESP and a load goes to WAIT_R.
- WAIT_R: `mem_req`=0. On `mem_rvalid`, register the aligned/extended data and go to RESP.
- RESP: `out_valid`=1 for exactly one cycle, then IDLE. The stage does not accept a new op in RESP.
- Store lanes:
  - SB: wdata = `{4{b}}`, be = `4'b0001 << addr[1:0]`.
  - SH: wdata = `{2{h}}`, be = `addr[1] ? 1100 : 0011`.
  - SW: be = 1111.
- Load be: 1111 for all loads.
- Load alignment: shift `mem_rdata` right by `8*addr[1:0]`.
  - B: sign-extend bit 7. BU: zero-extend.
  - H: sign-extend bit 15. HU: zero-extend.
  - W: pass through.
- `mem_rvalid` is ignored outside WAIT_R. `mem_gnt` is ignored outside REQ.

## Timing
- Reset: state IDLE. `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `out_valid`, `out_rdata`, `out_fault` and `stall` are all 0. `in_ready`=1 from the first cycle after reset.
- Load, gnt on the first REQ cycle, rvalid one cycle later: accept at cycle 0, `mem_req` at 1, rvalid at 2, `out_valid` at 3.
- Store with immediate gnt: accept at 0, `mem_req`/gnt at 1, `out_valid` at 2.
- Fault: accept at 0, `out_valid`+`out_fault` at 1.
- Earliest `mem_rvalid` is the cycle after grant; rvalid in the grant cycle is not supported.
- Each cycle of gnt or rvalid delay extends completion by exactly one cycle.
- `rst` mid-transaction: return to IDLE next cycle and drop `mem_req`. A late rvalid is ignored and no `out_valid` is produced.
- `out_rdata` and `out_fault` are registered and change only when entering RESP. They hold their values until the next RESP.

## Structure
- `lsu_pkg` holds:
  - funct3 constants `F3_LB`..`F3_LHU`
  - state enum `lsu_state_e`
  - `mem_req_t` struct (addr, we, be, wdata)
- Sub-module `load_align`: combinational shift plus sign/zero extension (`rdata`, `addr[1:0]`, `funct3` -> 32-bit result). Instantiated once and reused by the test bench as a reference model.

## Test plan
- LB at addr 0x103, mem_rdata 0x80FF_1234, gnt immediate, rvalid next cycle -> `out_rdata` 0xFFFF_FF80 at cycle 3, `out_fault`=0.
- LHU at addr 0x102, mem_rdata 0x8001_0000 -> `out_rdata` 0x0000_8001. LH at the same address and data -> 0xFFFF_8001.
- SB at addr 0x21, wdata 0x0000_00AB -> `mem_be` 0010, `mem_wdata` 0xABAB_ABAB, `mem_addr` 0x20, `out_valid` at cycle 2.
- SW to addr 0x06 -> `out_fault`=1 and `out_valid` at cycle 1, `mem_req` never asserted. LW with funct3 011 at addr 0x0 -> same fault behaviour.
- gnt delayed 3 cycles on SH at 0x12 -> `mem_req`/addr/be(1100)/wdata stable across all REQ cycles, `stall` high throughout, `out_valid` at cycle 5.
- `rst` asserted in WAIT_R, rvalid arrives the cycle after -> no `out_valid`, IDLE with `in_ready`=1; a following LW at 0x40 completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store memory stage.
package lsu_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  // One data-memory request as presented on the mem_* port
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: shifts the addressed byte/half to bit 0
// and sign- or zero-extends according to funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  // Select the extension; unsupported codes never reach here as a valid load
  always_comb begin
    result = shifted;
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  result = {24'h000000, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  result = {16'h0000, shifted[15:0]};
      F3_LW:   result = shifted;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one transaction at a time over a
// req/gnt/rvalid port, stalling the pipeline while busy.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_addr,
  input  logic [W-1:0] in_wdata,
  input  logic         in_we,
  input  logic [2:0]   in_funct3,
  output logic         stall,
  output logic         mem_req,
  input  logic         mem_gnt,
  output logic [W-1:0] mem_addr,
  output logic         mem_we,
  output logic [3:0]   mem_be,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_rvalid,
  input  logic [W-1:0] mem_rdata,
  output logic         out_valid,
  output logic [W-1:0] out_rdata,
  output logic         out_fault
);

  lsu_state_e  state;
  mem_req_t    req_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic [31:0] load_result;

  // Misaligned half/word, reserved funct3, or unsigned-store encodings
  function automatic logic is_fault(input logic [1:0] addr_lo,
                                    input logic       we,
                                    input logic [2:0] f3);
    logic f;
    case (f3)
      F3_LB:   f = 1'b0;
      F3_LBU:  f = we;
      F3_LH:   f = addr_lo[0];
      F3_LHU:  f = we | addr_lo[0];
      F3_LW:   f = (addr_lo != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  // Word-aligned address, byte enables and lane-replicated store data
  function automatic mem_req_t build_req(input logic [31:0] addr,
                                         input logic [31:0] wdata,
                                         input logic        we,
                                         input logic [2:0]  f3);
    mem_req_t r;
    r.addr  = {addr[31:2], 2'b00};
    r.we    = we;
    r.be    = 4'b1111;
    r.wdata = 32'h0000_0000;
    if (we) begin
      case (f3)
        F3_LB: begin
          r.be    = 4'b0001 << addr[1:0];
          r.wdata = {4{wdata[7:0]}};
        end
        F3_LH: begin
          r.be    = addr[1] ? 4'b1100 : 4'b0011;
          r.wdata = {2{wdata[15:0]}};
        end
        default: begin
          r.be    = 4'b1111;
          r.wdata = wdata;
        end
      endcase
    end
    return r;
  endfunction

  load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .result  (load_result)
  );

  assign mem_addr  = req_q.addr;
  assign mem_we    = req_q.we;
  assign mem_be    = req_q.be;
  assign mem_wdata = req_q.wdata;

  // Transaction FSM with all handshake and result outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      addr_lo_q <= 2'b00;
      funct3_q  <= 3'b000;
      in_ready  <= 1'b1;
      stall     <= 1'b0;
      mem_req   <= 1'b0;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            addr_lo_q <= in_addr[1:0];
            funct3_q  <= in_funct3;
            in_ready  <= 1'b0;
            stall     <= 1'b1;
            if (is_fault(in_addr[1:0], in_we, in_funct3)) begin
              state     <= RESP;
              out_valid <= 1'b1;
              out_fault <= 1'b1;
              out_rdata <= '0;
            end else begin
              state   <= REQ;
              req_q   <= build_req(in_addr, in_wdata, in_we, in_funct3);
              mem_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (req_q.we) begin
              state     <= RESP;
              out_valid <= 1'b1;
              out_fault <= 1'b0;
              out_rdata <= '0;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            state     <= RESP;
            out_valid <= 1'b1;
            out_fault <= 1'b0;
            out_rdata <= load_result;
          end
        end
        RESP: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          stall     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          stall     <= 1'b0;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
